// File: rtl/data_capture_buffer.sv
// data_capture_buffer: triggered capture of DEPTH valid words into RAM with registered random-access readout
//   Build option: define CAPTURE_CHECKSUM_EN to enable the running XOR checksum (tied to 0 otherwise).
//   clock/reset : rising-edge clock, synchronous active-high reset
//   data_start  : capture trigger pulse; data_in/data_valid: sample stream
//   clear       : acknowledge DONE and return to IDLE
//   rd_addr     : read address; rd_data: registered read data (1-cycle latency)
//   busy/done   : in CAPTURE / in DONE; wr_count: words captured this trigger
//   trig_miss   : sticky, trigger seen while capturing; checksum: XOR of captured words
module data_capture_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_start,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_valid,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              trig_miss,
  output logic [WIDTH-1:0]  checksum
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr_en, last_wr, enter_cap, in_range;
  always_comb begin
    wr_en     = state == CAPTURE && data_valid;
    last_wr   = wr_en && wr_count == (ADDR_W+1)'(DEPTH - 1);
    enter_cap = state != CAPTURE && data_start;
    in_range  = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);
    state_nxt = enter_cap ? CAPTURE :
                last_wr ? DONE :
                (state == DONE && clear) ? IDLE : state;
    busy      = state == CAPTURE;
    done      = state == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count  <= '0;
      trig_miss <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (enter_cap) wr_count <= '0;
      else if (wr_en) wr_count <= wr_count + (ADDR_W+1)'(1);
      trig_miss <= trig_miss | (busy && data_start);
      rd_data   <= in_range ? mem[rd_addr] : '0;
    end
  end
  // RAM is deliberately left out of reset so partial captures survive it
  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem[wr_count[ADDR_W-1:0]] <= data_in;
  end
`ifdef CAPTURE_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset || enter_cap) checksum <= '0;
    else if (wr_en) checksum <= checksum ^ data_in;
  end
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_data_capture_buffer.sv
// tb_data_capture_buffer: randomized self-checking bench for data_capture_buffer
module tb_data_capture_buffer;
  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 3;
`ifdef CAPTURE_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0, data_start = 1'b0, data_valid = 1'b0, clear = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [A-1:0] rd_addr = '0;
  logic [W-1:0] rd_data, checksum;
  logic busy, done, trig_miss;
  logic [A:0] wr_count;
  int passed = 0, total = 0;
  logic [W-1:0] exp_mem [D];

  data_capture_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .data_start(data_start), .data_in(data_in),
    .data_valid(data_valid), .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .wr_count(wr_count), .trig_miss(trig_miss), .checksum(checksum)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [W-1:0] d);
    data_start = s;
    data_valid = v;
    data_in = d;
    tick();
    data_start = 1'b0;
    data_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    total++; if (wr_count !== 4'd0) $display("FAIL reset_wr_count got %0d exp 0", wr_count); else passed++;
    total++; if (trig_miss !== 1'b0) $display("FAIL reset_trig_miss got %b exp 0", trig_miss); else passed++;
    total++; if (rd_data !== 16'h0) $display("FAIL reset_rd_data got %h exp 0000", rd_data); else passed++;
    total++; if (checksum !== 16'h0) $display("FAIL reset_checksum got %h exp 0000", checksum); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] x;
    x = '0;
    drive(1'b1, 1'b0, '0);
    total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else passed++;
    total++; if (wr_count !== 4'd0) $display("FAIL basic_start_count got %0d exp 0", wr_count); else passed++;
    for (int i = 0; i < D; i++) begin
      exp_mem[i] = W'(i + 1);
      x ^= exp_mem[i];
      drive(1'b0, 1'b1, exp_mem[i]);
      total++; if (wr_count !== 4'(i + 1)) $display("FAIL basic_count[%0d] got %0d exp %0d", i, wr_count, i + 1); else passed++;
    end
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", done, busy); else passed++;
    total++; if (trig_miss !== 1'b0) $display("FAIL basic_trig_miss got %b exp 0", trig_miss); else passed++;
    total++; if (checksum !== (CS ? x : 16'h0)) $display("FAIL basic_checksum got %h exp %h", checksum, CS ? x : 16'h0); else passed++;
    for (int a = 0; a < D; a++) begin
      rd_addr = A'(a);
      tick();
      total++; if (rd_data !== exp_mem[a]) $display("FAIL basic_read[%0d] got %h exp %h", a, rd_data, exp_mem[a]); else passed++;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_clear got done=%b busy=%b exp 0 0", done, busy); else passed++;
  endtask

  task automatic test_start_word_skipped();
    drive(1'b1, 1'b1, 16'hDEAD);
    total++; if (wr_count !== 4'd0) $display("FAIL skip_count got %0d exp 0", wr_count); else passed++;
    for (int i = 0; i < D; i++) begin
      exp_mem[i] = W'(32'h1111 * (i + 1));
      drive(1'b0, 1'b1, exp_mem[i]);
    end
    total++; if (done !== 1'b1) $display("FAIL skip_done got %b exp 1", done); else passed++;
    for (int a = 0; a < D; a++) begin
      rd_addr = A'(a);
      tick();
      total++; if (rd_data !== exp_mem[a]) $display("FAIL skip_read[%0d] got %h exp %h", a, rd_data, exp_mem[a]); else passed++;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_valid_toggle();
    int cnt;
    logic [W-1:0] d;
    logic v;
    cnt = 0;
    drive(1'b1, 1'b0, '0);
    for (int c = 0; c < 2 * D; c++) begin
      v = (c % 2) == 1;
      d = W'($urandom);
      drive(1'b0, v, d);
      if (v) begin
        exp_mem[cnt] = d;
        cnt++;
      end
      total++; if (wr_count !== 4'(cnt)) $display("FAIL toggle_count[%0d] got %0d exp %0d", c, wr_count, cnt); else passed++;
      total++; if (busy !== (c < 2 * D - 1)) $display("FAIL toggle_busy[%0d] got %b exp %b", c, busy, c < 2 * D - 1); else passed++;
    end
    total++; if (done !== 1'b1) $display("FAIL toggle_done got %b exp 1", done); else passed++;
    for (int a = 0; a < D; a++) begin
      rd_addr = A'(a);
      tick();
      total++; if (rd_data !== exp_mem[a]) $display("FAIL toggle_read[%0d] got %h exp %h", a, rd_data, exp_mem[a]); else passed++;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_trig_miss();
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < D; i++) begin
      exp_mem[i] = W'($urandom);
      drive(i == 2, 1'b1, exp_mem[i]);
      total++; if (wr_count !== 4'(i + 1)) $display("FAIL miss_count[%0d] got %0d exp %0d", i, wr_count, i + 1); else passed++;
    end
    total++; if (trig_miss !== 1'b1) $display("FAIL miss_flag got %b exp 1", trig_miss); else passed++;
    total++; if (done !== 1'b1) $display("FAIL miss_done got %b exp 1", done); else passed++;
    for (int a = 0; a < D; a++) begin
      rd_addr = A'(a);
      tick();
      total++; if (rd_data !== exp_mem[a]) $display("FAIL miss_read[%0d] got %h exp %h", a, rd_data, exp_mem[a]); else passed++;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (trig_miss !== 1'b1) $display("FAIL miss_sticky got %b exp 1", trig_miss); else passed++;
  endtask

  task automatic test_reset_mid_capture();
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      exp_mem[i] = W'($urandom);
      drive(1'b0, 1'b1, exp_mem[i]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rmid_state got busy=%b done=%b exp 0 0", busy, done); else passed++;
    total++; if (wr_count !== 4'd0) $display("FAIL rmid_count got %0d exp 0", wr_count); else passed++;
    total++; if (trig_miss !== 1'b0) $display("FAIL rmid_trig_miss got %b exp 0", trig_miss); else passed++;
    for (int a = 0; a < 4; a++) begin
      rd_addr = A'(a);
      tick();
      total++; if (rd_data !== exp_mem[a]) $display("FAIL rmid_retain[%0d] got %h exp %h", a, rd_data, exp_mem[a]); else passed++;
    end
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < D; i++) begin
      exp_mem[i] = W'($urandom);
      drive(1'b0, 1'b1, exp_mem[i]);
    end
    for (int a = 0; a < D; a++) begin
      rd_addr = A'(a);
      tick();
      total++; if (rd_data !== exp_mem[a]) $display("FAIL rmid_recap[%0d] got %h exp %h", a, rd_data, exp_mem[a]); else passed++;
    end
  endtask

  task automatic test_checksum();
    logic [W-1:0] words [D];
    words = '{16'h00FF, 16'h0F0F, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < D; i++) drive(1'b0, 1'b1, words[i]);
    total++; if (wr_count !== 4'd8) $display("FAIL csum_count got %0d exp 8", wr_count); else passed++;
    total++; if (checksum !== (CS ? 16'hFFF0 : 16'h0)) $display("FAIL csum_done got %h exp %h", checksum, CS ? 16'hFFF0 : 16'h0); else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    total++; if (checksum !== (CS ? 16'hFFF0 : 16'h0)) $display("FAIL csum_hold got %h exp %h", checksum, CS ? 16'hFFF0 : 16'h0); else passed++;
  endtask

  task automatic test_start_clear();
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < D; i++) begin
      exp_mem[i] = W'($urandom);
      drive(1'b0, 1'b1, exp_mem[i]);
    end
    total++; if (done !== 1'b1) $display("FAIL sc_pre_done got %b exp 1", done); else passed++;
    clear = 1'b1;
    drive(1'b1, 1'b0, '0);
    total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL sc_state got busy=%b done=%b exp 1 0", busy, done); else passed++;
    total++; if (wr_count !== 4'd0) $display("FAIL sc_count got %0d exp 0", wr_count); else passed++;
    total++; if (checksum !== 16'h0) $display("FAIL sc_checksum got %h exp 0000", checksum); else passed++;
  endtask

  task automatic test_read_before_write();
    logic [W-1:0] d;
    d = ~exp_mem[0];
    rd_addr = '0;
    drive(1'b0, 1'b1, d);
    total++; if (rd_data !== exp_mem[0]) $display("FAIL rbw_old got %h exp %h", rd_data, exp_mem[0]); else passed++;
    tick();
    total++; if (rd_data !== d) $display("FAIL rbw_new got %h exp %h", rd_data, d); else passed++;
    exp_mem[0] = d;
    for (int i = 1; i < D; i++) begin
      exp_mem[i] = W'($urandom);
      drive(1'b0, 1'b1, exp_mem[i]);
    end
    total++; if (done !== 1'b1) $display("FAIL rbw_done got %b exp 1", done); else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] q [$];
    logic [W-1:0] d, x;
    logic v;
    for (int r = 0; r < 6; r++) begin
      q.delete();
      drive(1'b1, 1'($urandom), W'($urandom));
      for (int c = 0; c < 200 && q.size() < D; c++) begin
        v = 1'($urandom);
        d = W'($urandom);
        clear = 1'($urandom);
        drive(1'b0, v, d);
        if (v) q.push_back(d);
        total++; if (wr_count !== 4'(q.size())) $display("FAIL rand%0d_count got %0d exp %0d", r, wr_count, q.size()); else passed++;
        total++; if (busy !== (q.size() < D)) $display("FAIL rand%0d_busy got %b exp %b", r, busy, q.size() < D); else passed++;
      end
      total++; if (done !== 1'b1) $display("FAIL rand%0d_done got %b exp 1", r, done); else passed++;
      x = '0;
      foreach (q[i]) x ^= q[i];
      total++; if (checksum !== (CS ? x : 16'h0)) $display("FAIL rand%0d_checksum got %h exp %h", r, checksum, CS ? x : 16'h0); else passed++;
      for (int a = D - 1; a >= 0; a--) begin
        rd_addr = A'(a);
        tick();
        total++; if (rd_data !== q[a]) $display("FAIL rand%0d_read[%0d] got %h exp %h", r, a, rd_data, q[a]); else passed++;
      end
      if ($urandom_range(0, 1) == 1) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_word_skipped();
    test_valid_toggle();
    test_trig_miss();
    test_reset_mid_capture();
    test_checksum();
    test_start_clear();
    test_read_before_write();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
